// File: rtl/fan_mode_ctrl_if.sv
// fan_mode_ctrl_if: signal bundle between the fan control core and its
// neighbours (button edge detectors, temperature reader and emergency
// logic on one side; fan driver, LED bar and FND mux on the other).
//
// Handshake: temp is a qualified data bus with no backpressure. The core
// samples temp on every clock edge where temp_valid=1; its ready is
// permanently 1. The btn_*_pe inputs are single-cycle event pulses and the
// core acts on them once per asserted cycle. timeout is a one-cycle event
// output. All other outputs are levels.
interface fan_mode_ctrl_if;
  logic        btn_speed_pe;
  logic        btn_auto_pe;
  logic        btn_timer_pe;
  logic        emcy;
  logic [7:0]  temp;
  logic        temp_valid;
  logic        pwm;
  logic [3:0]  level;
  logic        auto_mode;
  logic [1:0]  timer_sel;
  logic [15:0] timer_remain;
  logic        timeout;
  logic        emcy_active;

  // Driver side: produces buttons, emergency and temperature.
  modport master (
    output btn_speed_pe, btn_auto_pe, btn_timer_pe, emcy, temp, temp_valid,
    input  pwm, level, auto_mode, timer_sel, timer_remain, timeout, emcy_active
  );

  // Core side.
  modport slave (
    input  btn_speed_pe, btn_auto_pe, btn_timer_pe, emcy, temp, temp_valid,
    output pwm, level, auto_mode, timer_sel, timer_remain, timeout, emcy_active
  );
endinterface

// File: rtl/fan_mode_ctrl.sv
// fan_mode_ctrl: fan control core. Manual N-level speed, temperature
// driven auto mode, preset off-timer, emergency gating and a glitch-free
// PWM output whose duty only changes at period boundaries.
//
// Optional build macro: FAN_SOFT_START_EN. When defined, duty walks toward
// its target by RAMP_STEP per PWM period (up and down, never overshooting).
// When undefined, duty jumps to the target at the next period boundary.
//
// The mode FSM (manual/auto) is visible directly on auto_mode.
module fan_mode_ctrl #(
  parameter int SPEED_LEVELS = 3,
  parameter int PWM_BITS     = 8,
  parameter int DUTY_STEP    = 85,
  parameter int RAMP_STEP    = 4,
  parameter int TICK_DIV     = 100000000,
  parameter int TIMER_STEP_S = 3600,
  parameter int TIMER_STEPS  = 3,
  parameter int T_BASE       = 25,
  parameter int T_STEP_LOG2  = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  fan_mode_ctrl_if.slave bus
);

  localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [PWM_BITS-1:0] PWM_MAX_B  = '1;
  localparam logic [31:0]         PWM_MAX_32 = (32'd1 << PWM_BITS) - 32'd1;
  localparam logic [3:0]          LEVELS_B   = 4'(SPEED_LEVELS);
  localparam logic [8:0]          LEVELS_9   = 9'(SPEED_LEVELS);
  localparam logic [1:0]          STEPS_B    = 2'(TIMER_STEPS);
  localparam logic [7:0]          T_BASE_B   = 8'(T_BASE);

  // Out-of-range parameters would silently truncate the narrow output ports.
  if (SPEED_LEVELS < 1 || SPEED_LEVELS > 15 || TIMER_STEPS < 1 ||
      TIMER_STEPS > 3 || RAMP_STEP < 1) begin : g_bad_param
    $error("fan_mode_ctrl: parameter out of range");
  end

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_AUTO   = 1'b1
  } mode_t;

  mode_t               mode_q, mode_d;
  logic [3:0]          level_q, level_d;
  logic [1:0]          sel_q, sel_d;
  logic [15:0]         remain_q, remain_d;
  logic                timeout_q, timeout_d;
  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [7:0]          last_temp_q;
  logic [PWM_BITS-1:0] cnt_q, duty_q, duty_d, target;

  logic                tick, expire, step_to_zero;
  logic [7:0]          temp_over;
  logic [8:0]          lvl_calc;
  logic [3:0]          auto_level;
  logic [31:0]         level_prod;

  // Prescaler terminal count is the 1 s tick; it is frozen during emergency.
  assign tick   = (presc_q == PRESC_LAST) && !bus.emcy;
  assign expire = tick && (remain_q == 16'd1);

  // Auto level from the last valid temperature reading.
  always_comb begin
    temp_over = last_temp_q - T_BASE_B;
    lvl_calc  = {1'b0, temp_over >> T_STEP_LOG2} + 9'd1;
    if (last_temp_q < T_BASE_B) auto_level = '0;
    else if (lvl_calc > LEVELS_9) auto_level = LEVELS_B;
    else auto_level = lvl_calc[3:0];
  end

  // Mode FSM next state, level, timer and prescaler next values.
  // Priority: timer expiry over auto button over speed button.
  always_comb begin
    mode_d       = mode_q;
    level_d      = level_q;
    sel_d        = sel_q;
    remain_d     = remain_q;
    timeout_d    = 1'b0;
    presc_d      = presc_q;
    step_to_zero = 1'b0;

    if (bus.emcy) presc_d = presc_q;
    else if (tick) presc_d = '0;
    else presc_d = presc_q + PRESC_W'(1);

    if (expire) begin
      mode_d  = MODE_MANUAL;
      level_d = '0;
    end else if (bus.btn_auto_pe) begin
      mode_d = (mode_q == MODE_AUTO) ? MODE_MANUAL : MODE_AUTO;
    end else if (bus.btn_speed_pe) begin
      if (mode_q == MODE_AUTO) begin
        mode_d = MODE_MANUAL;
      end else if (level_q == LEVELS_B) begin
        level_d      = '0;
        step_to_zero = 1'b1;
      end else begin
        level_d = level_q + 4'd1;
      end
    end else if (mode_q == MODE_AUTO) begin
      level_d = auto_level;
    end

    // Timer press is judged against the already-updated level/mode.
    if (expire) begin
      sel_d     = '0;
      remain_d  = '0;
      timeout_d = 1'b1;
    end else if (step_to_zero) begin
      sel_d    = '0;
      remain_d = '0;
    end else if (bus.btn_timer_pe && (level_d != 4'd0 || mode_d == MODE_AUTO)) begin
      sel_d    = (sel_q == STEPS_B) ? 2'd0 : sel_q + 2'd1;
      remain_d = 16'(32'(sel_d) * TIMER_STEP_S);
      presc_d  = '0;
    end else if (tick && remain_q != 16'd0) begin
      remain_d = remain_q - 16'd1;
    end
  end

  // Target duty for the current level, saturated to the counter range.
  always_comb begin
    level_prod = {28'd0, level_q} * 32'(DUTY_STEP);
    if (level_q == 4'd0) target = '0;
    else if (level_prod > PWM_MAX_32) target = PWM_MAX_B;
    else target = level_prod[PWM_BITS-1:0];
  end

  // Duty next value: cleared by emergency, otherwise updated only at the
  // last count of a period so a period never changes shape mid-way.
`ifdef FAN_SOFT_START_EN
  localparam int RAMP_CLAMP = (RAMP_STEP > int'(PWM_MAX_32)) ? int'(PWM_MAX_32) : RAMP_STEP;
  localparam logic [PWM_BITS-1:0] RAMP_B = PWM_BITS'(RAMP_CLAMP);
  always_comb begin
    duty_d = duty_q;
    if (bus.emcy) begin
      duty_d = '0;
    end else if (cnt_q == PWM_MAX_B) begin
      if (duty_q < target)
        duty_d = ((target - duty_q) > RAMP_B) ? duty_q + RAMP_B : target;
      else if (duty_q > target)
        duty_d = ((duty_q - target) > RAMP_B) ? duty_q - RAMP_B : target;
    end
  end
`else
  always_comb begin
    duty_d = duty_q;
    if (bus.emcy) duty_d = '0;
    else if (cnt_q == PWM_MAX_B) duty_d = target;
  end
`endif

  // Mode FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) mode_q <= MODE_MANUAL;
    else mode_q <= mode_d;
  end

  // Datapath registers: level, timer, prescaler, temperature, PWM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_q     <= '0;
      sel_q       <= '0;
      remain_q    <= '0;
      timeout_q   <= 1'b0;
      presc_q     <= '0;
      last_temp_q <= '0;
      cnt_q       <= '0;
      duty_q      <= '0;
    end else begin
      level_q   <= level_d;
      sel_q     <= sel_d;
      remain_q  <= remain_d;
      timeout_q <= timeout_d;
      presc_q   <= presc_d;
      cnt_q     <= cnt_q + PWM_BITS'(1);
      duty_q    <= duty_d;
      if (bus.temp_valid) last_temp_q <= bus.temp;
    end
  end

  // Emergency gates the pin combinationally, ahead of the duty clear.
  assign bus.pwm          = (cnt_q < duty_q) & ~bus.emcy;
  assign bus.level        = level_q;
  assign bus.auto_mode    = (mode_q == MODE_AUTO);
  assign bus.timer_sel    = sel_q;
  assign bus.timer_remain = remain_q;
  assign bus.timeout      = timeout_q;
  assign bus.emcy_active  = bus.emcy;

endmodule

// File: tb/tb_fan_mode_ctrl.sv
// tb_fan_mode_ctrl: directed bench for fan_mode_ctrl with small parameters
// (4-bit PWM, 10-cycle tick, 2 s timer step). A vector table covers the
// single-cycle level/mode behaviour; hand sequences cover PWM periods,
// timer expiry, emergency stop and mid-run reset.
module tb_fan_mode_ctrl;

  logic clk;
  logic reset_n;
  fan_mode_ctrl_if bus ();

  fan_mode_ctrl #(
    .SPEED_LEVELS(3), .PWM_BITS(4), .DUTY_STEP(5), .RAMP_STEP(2),
    .TICK_DIV(10), .TIMER_STEP_S(2), .TIMER_STEPS(3),
    .T_BASE(25), .T_STEP_LOG2(2)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Position of the 16-cycle PWM period, counted from reset release.
  logic [3:0] cnt_m;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_m <= 4'd0;
    else cnt_m <= cnt_m + 4'd1;
  end

  int total = 0;
  int bad   = 0;
  int step_cnt = 0;
  logic [7:0] exp_q[$];

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    step_cnt++;
  endtask

  task automatic pulse(input logic s, input logic a, input logic t);
    bus.btn_speed_pe = s;
    bus.btn_auto_pe  = a;
    bus.btn_timer_pe = t;
    step();
    bus.btn_speed_pe = 1'b0;
    bus.btn_auto_pe  = 1'b0;
    bus.btn_timer_pe = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // High cycles over the next complete PWM period.
  task automatic measure_period(output int hi);
    int guard;
    hi = 0;
    guard = 0;
    while (cnt_m != 4'd0 && guard < 20) begin
      step();
      guard++;
    end
    for (int i = 0; i < 16; i++) begin
      if (bus.pwm) hi++;
      step();
    end
  endtask

  // Compares measured periods against the expected queue.
  task automatic drain_periods(input string name);
    int hi;
    logic [7:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      measure_period(hi);
      check(name, hi, {24'd0, e});
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        spd;
    logic        aut;
    logic        tmr;
    logic        tv;
    logic [7:0]  tp;
    logic [3:0]  e_level;
    logic        e_auto;
    logic [1:0]  e_sel;
    logic [15:0] e_remain;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic a, input logic t,
                              input logic v, input logic [7:0] tp,
                              input logic [3:0] l, input logic am,
                              input logic [1:0] sl, input logic [15:0] rm);
    vec_t r;
    r.spd = s; r.aut = a; r.tmr = t; r.tv = v; r.tp = tp;
    r.e_level = l; r.e_auto = am; r.e_sel = sl; r.e_remain = rm;
    return r;
  endfunction

  vec_t vecs[20];

  // ---------------- main sequence ----------------
  initial begin
    int hi, cnt_to, first_k, s0, guard;

    bus.btn_speed_pe = 1'b0;
    bus.btn_auto_pe  = 1'b0;
    bus.btn_timer_pe = 1'b0;
    bus.emcy         = 1'b0;
    bus.temp         = 8'd0;
    bus.temp_valid   = 1'b0;
    reset_n          = 1'b0;

    //         spd  aut  tmr  tv   temp  level auto sel remain
    vecs[0]  = mk(1, 0, 0, 0, 8'd0,  4'd1, 0, 2'd0, 16'd0);
    vecs[1]  = mk(1, 0, 0, 0, 8'd0,  4'd2, 0, 2'd0, 16'd0);
    vecs[2]  = mk(1, 0, 0, 0, 8'd0,  4'd3, 0, 2'd0, 16'd0);
    vecs[3]  = mk(1, 0, 0, 0, 8'd0,  4'd0, 0, 2'd0, 16'd0);
    vecs[4]  = mk(0, 1, 0, 0, 8'd0,  4'd0, 1, 2'd0, 16'd0);
    vecs[5]  = mk(0, 0, 0, 1, 8'd24, 4'd0, 1, 2'd0, 16'd0);
    vecs[6]  = mk(0, 0, 0, 1, 8'd25, 4'd1, 1, 2'd0, 16'd0);
    vecs[7]  = mk(0, 0, 0, 1, 8'd29, 4'd2, 1, 2'd0, 16'd0);
    vecs[8]  = mk(0, 0, 0, 1, 8'd40, 4'd3, 1, 2'd0, 16'd0);
    vecs[9]  = mk(1, 0, 0, 0, 8'd0,  4'd3, 0, 2'd0, 16'd0);
    vecs[10] = mk(0, 0, 0, 1, 8'd24, 4'd3, 0, 2'd0, 16'd0);
    vecs[11] = mk(1, 0, 0, 0, 8'd0,  4'd0, 0, 2'd0, 16'd0);
    vecs[12] = mk(1, 0, 0, 0, 8'd0,  4'd1, 0, 2'd0, 16'd0);
    vecs[13] = mk(0, 0, 0, 1, 8'd27, 4'd1, 0, 2'd0, 16'd0);
    vecs[14] = mk(1, 1, 0, 0, 8'd0,  4'd1, 1, 2'd0, 16'd0);
    vecs[15] = mk(0, 1, 0, 0, 8'd0,  4'd1, 0, 2'd0, 16'd0);
    vecs[16] = mk(1, 0, 0, 0, 8'd0,  4'd2, 0, 2'd0, 16'd0);
    vecs[17] = mk(1, 0, 0, 0, 8'd0,  4'd3, 0, 2'd0, 16'd0);
    vecs[18] = mk(1, 0, 0, 0, 8'd0,  4'd0, 0, 2'd0, 16'd0);
    vecs[19] = mk(0, 0, 1, 0, 8'd0,  4'd0, 0, 2'd0, 16'd0);

    // Reset state, checked while reset is held.
    repeat (3) @(posedge clk);
    #1;
    check("rst_level", {28'd0, bus.level}, 0);
    check("rst_auto", {31'd0, bus.auto_mode}, 0);
    check("rst_sel", {30'd0, bus.timer_sel}, 0);
    check("rst_remain", {16'd0, bus.timer_remain}, 0);
    check("rst_timeout", {31'd0, bus.timeout}, 0);
    check("rst_pwm", {31'd0, bus.pwm}, 0);
    reset_n = 1'b1;
    step();

    // Table: one input cycle, two settle cycles, then compare.
    for (int i = 0; i < 20; i++) begin
      bus.temp       = vecs[i].tp;
      bus.temp_valid = vecs[i].tv;
      bus.btn_speed_pe = vecs[i].spd;
      bus.btn_auto_pe  = vecs[i].aut;
      bus.btn_timer_pe = vecs[i].tmr;
      step();
      bus.temp_valid   = 1'b0;
      bus.btn_speed_pe = 1'b0;
      bus.btn_auto_pe  = 1'b0;
      bus.btn_timer_pe = 1'b0;
      step();
      step();
      check($sformatf("v%0d_level", i), {28'd0, bus.level}, {28'd0, vecs[i].e_level});
      check($sformatf("v%0d_auto", i), {31'd0, bus.auto_mode}, {31'd0, vecs[i].e_auto});
      check($sformatf("v%0d_sel", i), {30'd0, bus.timer_sel}, {30'd0, vecs[i].e_sel});
      check($sformatf("v%0d_remain", i), {16'd0, bus.timer_remain}, {16'd0, vecs[i].e_remain});
    end

    // PWM at level 3: presses land just after a period boundary.
    repeat (48) step();
    guard = 0;
    while (cnt_m != 4'd1 && guard < 20) begin step(); guard++; end
    pulse(1, 0, 0);
    pulse(1, 0, 0);
    pulse(1, 0, 0);
    check("pwm_l3_level", {28'd0, bus.level}, 3);
`ifdef FAN_SOFT_START_EN
    for (int d = 2; d <= 14; d += 2) exp_q.push_back(8'(d));
    exp_q.push_back(8'd15);
    exp_q.push_back(8'd15);
`else
    exp_q.push_back(8'd15);
    exp_q.push_back(8'd15);
`endif
    drain_periods("pwm_l3_period");

    // Timer: level 1, two presses -> 4 s, expiry after 40 cycles.
    pulse(1, 0, 0);
    pulse(1, 0, 0);
    check("tmr_level1", {28'd0, bus.level}, 1);
    pulse(0, 0, 1);
    pulse(0, 0, 1);
    check("tmr_sel2", {30'd0, bus.timer_sel}, 2);
    check("tmr_remain4", {16'd0, bus.timer_remain}, 4);
    cnt_to = 0;
    first_k = 0;
    for (int k = 1; k <= 60; k++) begin
      step();
      if (bus.timeout) begin
        cnt_to++;
        if (first_k == 0) first_k = k;
      end
      if (k == 15) check("tmr_remain_mid", {16'd0, bus.timer_remain}, 3);
    end
    check("tmr_timeout_count", cnt_to, 1);
    check("tmr_timeout_cycle", first_k, 40);
    check("tmr_end_level", {28'd0, bus.level}, 0);
    check("tmr_end_sel", {30'd0, bus.timer_sel}, 0);
    check("tmr_end_remain", {16'd0, bus.timer_remain}, 0);

    // Emergency: level 2, timer at 6 s, emcy held 25 cycles.
    pulse(1, 0, 0);
    pulse(1, 0, 0);
    repeat (96) step();
    guard = 0;
    while (cnt_m != 4'd2 && guard < 20) begin step(); guard++; end
    pulse(0, 0, 1);
    pulse(0, 0, 1);
    pulse(0, 0, 1);
    check("emcy_pre_sel", {30'd0, bus.timer_sel}, 3);
    check("emcy_pre_remain", {16'd0, bus.timer_remain}, 6);
    check("emcy_pre_pwm", {31'd0, bus.pwm}, 1);
    bus.emcy = 1'b1;
    #1;
    check("emcy_pwm_same_cycle", {31'd0, bus.pwm}, 0);
    check("emcy_active", {31'd0, bus.emcy_active}, 1);
    hi = 0;
    for (int k = 0; k < 25; k++) begin
      step();
      if (bus.pwm) hi++;
    end
    check("emcy_pwm_highs", hi, 0);
    check("emcy_remain_frozen", {16'd0, bus.timer_remain}, 6);
    check("emcy_level_kept", {28'd0, bus.level}, 2);
    check("emcy_sel_kept", {30'd0, bus.timer_sel}, 3);
    bus.emcy = 1'b0;
    s0 = step_cnt;
    hi = 0;
    guard = 0;
    while (cnt_m != 4'd0 && guard < 20) begin
      if (bus.pwm) hi++;
      step();
      guard++;
    end
    check("emcy_release_partial", hi, 0);
    check("emcy_release_inactive", {31'd0, bus.emcy_active}, 0);
`ifdef FAN_SOFT_START_EN
    exp_q.push_back(8'd2);
`else
    exp_q.push_back(8'd10);
`endif
    drain_periods("emcy_release_period");
    check("emcy_resume_remain", {16'd0, bus.timer_remain}, 6 - (step_cnt - s0) / 10);

    // Reset mid-run with timer active.
    repeat (3) step();
    reset_n = 1'b0;
    #1;
    check("mid_rst_level", {28'd0, bus.level}, 0);
    check("mid_rst_sel", {30'd0, bus.timer_sel}, 0);
    check("mid_rst_remain", {16'd0, bus.timer_remain}, 0);
    check("mid_rst_pwm", {31'd0, bus.pwm}, 0);
    step();
    step();
    reset_n = 1'b1;
    hi = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.pwm) hi++;
      step();
    end
    check("post_rst_pwm_highs", hi, 0);
    check("post_rst_level", {28'd0, bus.level}, 0);
    check("post_rst_auto", {31'd0, bus.auto_mode}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Time bound for the whole run.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
